acc_operand_unit: RTL and testbench



---
 rtl/acc_pkg.sv | 8 +
 rtl/acc_shift_add_mul.sv | 53 +++++
 rtl/acc_operand_unit.sv | 81 ++++++++
 tb/tb_acc_operand_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared op/state encodings, default width and saturation limits for acc_operand_unit
package acc_pkg;
  localparam int ACC_WIDTH = 16;
  typedef enum logic [2:0] {OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL1, OP_MUL} op_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam logic [ACC_WIDTH-1:0] SAT_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};
endpackage

// File: rtl/acc_shift_add_mul.sv
// acc_shift_add_mul: iterative signed shift-add multiplier, one multiplier bit per cycle
module acc_shift_add_mul #(
  parameter int WIDTH = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             neg
);
  localparam int CW = $clog2(MUL_CYCLES);
  logic [2*WIDTH-1:0] mcand, pp, addend, pp_next;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  logic last;
  // The multiplier's top bit carries negative weight, so the final step subtracts.
  always_comb begin
    last = cnt == CW'(MUL_CYCLES - 1);
    addend = mplier[0] ? mcand : '0;
    pp_next = last ? pp - addend : pp + addend;
    done = busy && last;
    product = pp_next[WIDTH-1:0];
    neg = pp_next[2*WIDTH-1];
    ovf = pp_next[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){pp_next[WIDTH-1]}};
  end
  // Operand latch on start, then one shift-add step per busy cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      pp <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      pp <= '0;
      mcand <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
      mplier <= multiplier;
    end else if (busy) begin
      busy <= !last;
      cnt <= cnt + 1'b1;
      pp <= pp_next;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
endmodule

// File: rtl/acc_operand_unit.sv
// acc_operand_unit: accumulator execute stage with valid/ready intake; ACC_SATURATE_EN clamps overflowing results
module acc_operand_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int MUL_CYCLES = ACC_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Operand,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] Acc,
  output logic             Done,
  output logic             Z,
  output logic             N,
  output logic             V
);
`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  state_t state, next_state;
  op_t op;
  logic xfer, start, retire, mul_busy, mul_done, mul_ovf, mul_neg, ovf, v_new, sign;
  logic [WIDTH-1:0] mul_prod, b, sum, res, r, acc_new;
  acc_shift_add_mul #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(CLK), .rst(Reset), .start(start), .multiplicand(Operand), .multiplier(Acc),
    .busy(mul_busy), .done(mul_done), .product(mul_prod), .ovf(mul_ovf), .neg(mul_neg)
  );
  // Handshake and next state: only IDLE accepts, MUL holds until the multiplier finishes.
  always_comb begin
    op = op_t'(Op);
    In_Ready = state == S_IDLE && !mul_busy;
    xfer = In_Valid && In_Ready;
    start = xfer && op == OP_MUL;
    retire = mul_done || (xfer && op != OP_MUL);
    next_state = start ? S_MUL : mul_done ? S_IDLE : state;
  end
  // Single-cycle ALU plus retire-value selection; overflowing results keep the true sign when clamped.
  always_comb begin
    b = op == OP_SUB ? ~Operand : Operand;
    sum = Acc + b + WIDTH'(op == OP_SUB);
    ovf = (op == OP_ADD || op == OP_SUB) && Acc[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != Acc[WIDTH-1];
    case (op)
      OP_LOAD:         res = Operand;
      OP_ADD, OP_SUB:  res = sum;
      OP_AND:          res = Acc & Operand;
      OP_OR:           res = Acc | Operand;
      OP_SHL1:         res = {Acc[WIDTH-2:0], 1'b0};
      default:         res = Acc;
    endcase
    r = mul_done ? mul_prod : res;
    v_new = mul_done ? mul_ovf : ovf;
    sign = mul_done ? mul_neg : Acc[WIDTH-1];
    acc_new = SAT_EN && v_new ? (sign ? SAT_NEG : SAT_POS) : r;
  end
  // State register.
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= S_IDLE;
    else state <= next_state;
  // Accumulator, flags and the Done pulse update on every retire.
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      Acc <= '0;
      Z <= 1'b1;
      N <= 1'b0;
      V <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= retire;
      if (retire) begin
        Acc <= acc_new;
        Z <= acc_new == '0;
        N <= acc_new[WIDTH-1];
        V <= v_new;
      end
    end
endmodule

// File: tb/tb_acc_operand_unit.sv
// tb_acc_operand_unit: vector table, corner sequences and randomized ops checked against an arithmetic model
module tb_acc_operand_unit;
  import acc_pkg::*;
`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [15:0] val;
    logic [15:0] acc;
    logic        v;
  } vec_t;
  logic CLK = 1'b0, Reset, In_Valid, In_Ready, Done, Z, N, V;
  logic [15:0] Operand, Acc;
  logic [2:0] Op;
  int total = 0, bad = 0;
  vec_t tbl[25];
  acc_operand_unit dut (
    .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready), .Operand(Operand),
    .Op(Op), .Acc(Acc), .Done(Done), .Z(Z), .N(N), .V(V)
  );
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic v);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t = 0;
    v = 1'b0;
    r = a;
    case (op)
      3'd1: r = b;
      3'd2: t = sa + sb;
      3'd3: t = sa - sb;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a << 1;
      3'd7: t = sa * sb;
      default: ;
    endcase
    if (op inside {3'd2, 3'd3, 3'd7}) begin
      v = t > 32767 || t < -32768;
      r = (SAT && v) ? (t > 0 ? 16'h7FFF : 16'h8000) : t[15:0];
    end
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [15:0] val, output int lat);
    @(negedge CLK);
    In_Valid = 1'b1;
    Op = op;
    Operand = val;
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask
  task automatic apply(input string name, input logic [2:0] op, input logic [15:0] val,
                       input logic [15:0] acc, input logic v);
    int lat;
    run_op(op, val, lat);
    check({name, "_lat"}, lat, op == 3'd7 ? 16 : 0);
    check({name, "_acc"}, Acc, acc);
    check({name, "_z"}, Z, acc == 16'h0);
    check({name, "_n"}, N, acc[15]);
    check({name, "_v"}, V, v);
  endtask
  initial begin
    int lo, n, seen, lat;
    logic [15:0] macc, r, val;
    logic v;
    logic [2:0] op;
    logic [15:0] specials[5];
    specials = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    tbl = '{
      '{OP_LOAD, 16'h0008, 16'h0008, 1'b0},
      '{OP_ADD,  16'h0004, 16'h000C, 1'b0},
      '{OP_SUB,  16'h000C, 16'h0000, 1'b0},
      '{OP_LOAD, 16'h7FFF, 16'h7FFF, 1'b0},
      '{OP_ADD,  16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b1},
      '{OP_NOP,  16'h1234, SAT ? 16'h7FFF : 16'h8000, 1'b0},
      '{OP_LOAD, 16'h8000, 16'h8000, 1'b0},
      '{OP_SUB,  16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1},
      '{OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0},
      '{OP_ADD,  16'h0001, 16'h0000, 1'b0},
      '{OP_LOAD, 16'h0012, 16'h0012, 1'b0},
      '{OP_MUL,  16'h0003, 16'h0036, 1'b0},
      '{OP_LOAD, 16'h0100, 16'h0100, 1'b0},
      '{OP_MUL,  16'h0100, SAT ? 16'h7FFF : 16'h0000, 1'b1},
      '{OP_LOAD, 16'h0005, 16'h0005, 1'b0},
      '{OP_MUL,  16'h0000, 16'h0000, 1'b0},
      '{OP_LOAD, 16'hF0F0, 16'hF0F0, 1'b0},
      '{OP_AND,  16'h0FF0, 16'h00F0, 1'b0},
      '{OP_OR,   16'h000F, 16'h00FF, 1'b0},
      '{OP_SHL1, 16'h0000, 16'h01FE, 1'b0},
      '{OP_LOAD, 16'h8001, 16'h8001, 1'b0},
      '{OP_SHL1, 16'hAAAA, 16'h0002, 1'b0},
      '{OP_LOAD, 16'hFFFE, 16'hFFFE, 1'b0},
      '{OP_MUL,  16'h0003, 16'hFFFA, 1'b0},
      '{OP_SUB,  16'h0003, 16'hFFF7, 1'b0}
    };
    Reset = 1'b1;
    In_Valid = 1'b0;
    Op = 3'd0;
    Operand = 16'h0;
    repeat (2) @(negedge CLK);
    check("rst_acc", Acc, 16'h0);
    check("rst_z", Z, 1'b1);
    check("rst_n", N, 1'b0);
    check("rst_v", V, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_ready", In_Ready, 1'b1);
    Reset = 1'b0;
    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].val, tbl[i].acc, tbl[i].v);
    @(negedge CLK);
    In_Valid = 1'b1;
    Op = OP_LOAD;
    Operand = 16'h0008;
    @(negedge CLK);
    check("b2b_done1", Done, 1'b1);
    check("b2b_acc1", Acc, 16'h0008);
    Op = OP_ADD;
    Operand = 16'h0004;
    @(negedge CLK);
    check("b2b_done2", Done, 1'b1);
    check("b2b_acc2", Acc, 16'h000C);
    Op = OP_SUB;
    Operand = 16'h000C;
    @(negedge CLK);
    check("b2b_done3", Done, 1'b1);
    check("b2b_acc3", Acc, 16'h0000);
    check("b2b_z3", Z, 1'b1);
    In_Valid = 1'b0;
    @(negedge CLK);
    check("b2b_idle_done", Done, 1'b0);
    apply("held_load", OP_LOAD, 16'h0012, 16'h0012, 1'b0);
    @(negedge CLK);
    In_Valid = 1'b1;
    Op = OP_MUL;
    Operand = 16'h0003;
    @(posedge CLK);
    @(negedge CLK);
    Op = OP_AND;
    Operand = 16'h000F;
    lo = 0;
    n = 0;
    while (!Done && n < 40) begin
      if (!In_Ready) lo++;
      if (n == 8) check("held_mid_acc", Acc, 16'h0012);
      @(negedge CLK);
      n++;
    end
    check("held_ready_low", lo, 16);
    check("held_mul_done", Done, 1'b1);
    check("held_mul_acc", Acc, 16'h0036);
    check("held_mul_v", V, 1'b0);
    @(negedge CLK);
    check("held_and_done", Done, 1'b1);
    check("held_and_acc", Acc, 16'h0006);
    In_Valid = 1'b0;
    @(negedge CLK);
    check("held_after_done", Done, 1'b0);
    apply("rmid_load", OP_LOAD, 16'h0012, 16'h0012, 1'b0);
    @(negedge CLK);
    In_Valid = 1'b1;
    Op = OP_MUL;
    Operand = 16'h0003;
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    check("rmid_busy", In_Ready, 1'b0);
    Reset = 1'b1;
    #1;
    check("rmid_acc", Acc, 16'h0);
    check("rmid_z", Z, 1'b1);
    check("rmid_ready", In_Ready, 1'b1);
    check("rmid_done", Done, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Done) seen++;
    end
    check("rmid_no_done", seen, 0);
    check("rmid_acc_after", Acc, 16'h0);
    macc = 16'h0;
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(7));
      val = ($urandom % 4 == 0) ? specials[$urandom_range(4)] : 16'($urandom);
      if (k % 10 == 0) op = OP_LOAD;
      model(op, macc, val, r, v);
      apply($sformatf("rnd%0d", k), op, val, r, v);
      macc = r;
    end
    run_op(OP_NOP, 16'h0, lat);
    check("final_nop_lat", lat, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
